// File: rtl/subword_store_seq.sv
//------------------------------------------------------------------------------
// subword_store_seq
//
// Store sequencer that turns a pipeline store (sb/sh/sw/sd) into memory word
// commands. A store that covers a whole memory word becomes a single write.
// A narrower store becomes a read-modify-write:
//    1. read the aligned word
//    2. replace the addressed byte lanes with the store data
//    3. write the merged word back
//
// Parameters
//    DATA_W     memory word width in bits (32 or 64)
//    ADDR_W     byte-address width
//
// Ports
//    clk, rst                    clock; asynchronous active-high reset
//    st_valid / st_ready         store request handshake (ready only when idle)
//    st_addr, st_data, st_funct3 byte address, rs2 value, store size encoding
//                                (000 sb, 001 sh, 010 sw, 011 sd)
//    st_done                     one-cycle pulse when the store has retired
//    st_err                      one-cycle pulse when the store was rejected
//                                (no memory access was made)
//    mem_req, mem_we             memory command valid / write enable
//    mem_addr, mem_wdata         word-aligned address and write data
//    mem_gnt                     command accepted this cycle
//    mem_rvalid, mem_rdata       read response (only looked at in RD_WAIT)
//
// Build option
//    STORE_MISALIGN_CHECK_EN     when defined, a store that is not naturally
//                                aligned to its own size is rejected with
//                                st_err. When undefined, the low address bits
//                                below the access size are dropped and the
//                                store proceeds.
//------------------------------------------------------------------------------
module subword_store_seq #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   input  logic [2:0]        st_funct3,
   output logic              st_done,
   output logic              st_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int BYTES  = DATA_W / 8;
   localparam int LANE_W = $clog2(BYTES);
   localparam bit IS_64  = (DATA_W == 64);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_REQ  = 3'd1;
   localparam logic [2:0] S_RD_WAIT = 3'd2;
   localparam logic [2:0] S_WR_REQ  = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;
   localparam logic [2:0] S_ERR     = 3'd5;

   logic [2:0]        state_q,  state_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [DATA_W-1:0] data_q,   data_d;
   logic [2:0]        funct3_q, funct3_d;
   // Word presented on mem_wdata in WR_REQ: either the raw store data
   // (full-width store) or the merged read-modify-write result.
   logic [DATA_W-1:0] wdata_q,  wdata_d;

   //---------------------------------------------------------------------------
   // Classification of the incoming request (only meaningful in IDLE)
   //---------------------------------------------------------------------------
   logic req_unsupported;
   logic req_full;
   logic req_misaligned;

   always_comb begin
      // funct3[2]=1 is not a store encoding; sd cannot be done on a 32-bit word.
      req_unsupported = st_funct3[2] || (!IS_64 && (st_funct3[1:0] == 2'b11));
      req_full        = !st_funct3[2] &&
                        (( IS_64 && (st_funct3[1:0] == 2'b11)) ||
                         (!IS_64 && (st_funct3[1:0] == 2'b10)));
      req_misaligned  = 1'b0;
`ifdef STORE_MISALIGN_CHECK_EN
      case (st_funct3[1:0])
         2'b01:   req_misaligned = st_addr[0];
         2'b10:   req_misaligned = |st_addr[1:0];
         2'b11:   req_misaligned = |st_addr[2:0];
         default: req_misaligned = 1'b0;
      endcase
`endif
   end

   //---------------------------------------------------------------------------
   // Byte-lane merge, driven entirely by the captured request
   //---------------------------------------------------------------------------
   logic [LANE_W-1:0] lane_raw;
   logic [LANE_W-1:0] lane_mask;
   logic [LANE_W-1:0] lane;
   logic [BYTES-1:0]  size_bmask;
   logic [BYTES-1:0]  lane_bmask;
   logic [DATA_W-1:0] bit_mask;
   logic [DATA_W-1:0] data_shifted;
   logic [DATA_W-1:0] merged_word;

   always_comb begin
      lane_raw = addr_q[LANE_W-1:0];
      // lane_mask drops the address bits below the access size, so a
      // misaligned store (check disabled) lands on its natural boundary.
      case (funct3_q)
         3'b000: begin
            lane_mask  = {LANE_W{1'b1}};
            size_bmask = BYTES'(1);
         end
         3'b001: begin
            lane_mask  = {LANE_W{1'b1}} << 1;
            size_bmask = BYTES'(3);
         end
         3'b010: begin
            lane_mask  = {LANE_W{1'b1}} << 2;
            size_bmask = BYTES'(15);
         end
         default: begin
            lane_mask  = {LANE_W{1'b1}} << 3;
            size_bmask = {BYTES{1'b1}};
         end
      endcase
      lane         = lane_raw & lane_mask;
      lane_bmask   = size_bmask << lane;
      // Store data always sits in the low bytes of rs2; move it to its lane.
      data_shifted = data_q << {lane, 3'b000};
   end

   // Expand the per-byte enable into a per-bit mask.
   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_bit_mask
         assign bit_mask[gi*8 +: 8] = {8{lane_bmask[gi]}};
      end
   endgenerate

   assign merged_word = (mem_rdata & ~bit_mask) | (data_shifted & bit_mask);

   //---------------------------------------------------------------------------
   // Sequencer
   //---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      funct3_d = funct3_q;
      wdata_d  = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (st_valid) begin
               addr_d   = st_addr;
               data_d   = st_data;
               funct3_d = st_funct3;
               if (req_unsupported || req_misaligned) begin
                  state_d = S_ERR;
               end else if (req_full) begin
                  wdata_d = st_data;
                  state_d = S_WR_REQ;
               end else begin
                  state_d = S_RD_REQ;
               end
            end
         end
         S_RD_REQ: begin
            if (mem_gnt) begin
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            // The write can only be entered from here with the merged word
            // already registered, so a sub-word write never precedes its read.
            if (mem_rvalid) begin
               wdata_d = merged_word;
               state_d = S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            if (mem_gnt) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         data_q   <= '0;
         funct3_q <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         funct3_q <= funct3_d;
         wdata_q  <= wdata_d;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs (pure decode of the state and captured registers)
   //---------------------------------------------------------------------------
   logic in_cmd;

   assign in_cmd    = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
   assign st_ready  = (state_q == S_IDLE);
   assign st_done   = (state_q == S_DONE);
   assign st_err    = (state_q == S_ERR);
   assign mem_req   = in_cmd;
   assign mem_we    = (state_q == S_WR_REQ);
   assign mem_addr  = in_cmd ? {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
   assign mem_wdata = (state_q == S_WR_REQ) ? wdata_q : '0;

endmodule

// File: tb/tb_subword_store_seq.sv
//------------------------------------------------------------------------------
// tb_subword_store_seq
//
// Two sequencer instances (32-bit and 64-bit words) share one clock and reset.
// A memory responder grants commands and returns read data after programmable
// delays, and throws stray rvalid pulses whenever no read is outstanding.
// Each store pushes its expected event sequence (read / write / done / err,
// with the cycle each must appear in) onto a scoreboard queue; a monitor pops
// and compares every event the DUTs present.
//------------------------------------------------------------------------------
module tb_subword_store_seq;

   localparam int K_RD   = 0;
   localparam int K_WR   = 1;
   localparam int K_DONE = 2;
   localparam int K_ERR  = 3;

   typedef struct {
      int          unit;
      int          kind;
      logic [31:0] addr;
      logic [63:0] wdata;
      int          cyc;
   } ev_t;

   ev_t exp_q[$];

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [1:0]       st_valid, st_ready, st_done, st_err;
   logic [1:0]       mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [1:0][31:0] st_addr, mem_addr;
   logic [1:0][63:0] st_data, mem_wdata, mem_rdata;
   logic [1:0][2:0]  st_funct3;
   logic [31:0]      w32_wdata;
   logic [63:0]      w64_wdata;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // responder configuration / state
   int          gnt_cfg[2];
   int          gnt_cnt[2];
   int          rv_cfg[2];
   int          rv_cnt[2];
   bit          pend[2];
   logic [63:0] rd_cfg[2];

   subword_store_seq #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
      .clk        (clk),
      .rst        (rst),
      .st_valid   (st_valid[0]),
      .st_ready   (st_ready[0]),
      .st_addr    (st_addr[0]),
      .st_data    (st_data[0][31:0]),
      .st_funct3  (st_funct3[0]),
      .st_done    (st_done[0]),
      .st_err     (st_err[0]),
      .mem_req    (mem_req[0]),
      .mem_we     (mem_we[0]),
      .mem_addr   (mem_addr[0]),
      .mem_wdata  (w32_wdata),
      .mem_gnt    (mem_gnt[0]),
      .mem_rvalid (mem_rvalid[0]),
      .mem_rdata  (mem_rdata[0][31:0])
   );

   subword_store_seq #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
      .clk        (clk),
      .rst        (rst),
      .st_valid   (st_valid[1]),
      .st_ready   (st_ready[1]),
      .st_addr    (st_addr[1]),
      .st_data    (st_data[1]),
      .st_funct3  (st_funct3[1]),
      .st_done    (st_done[1]),
      .st_err     (st_err[1]),
      .mem_req    (mem_req[1]),
      .mem_we     (mem_we[1]),
      .mem_addr   (mem_addr[1]),
      .mem_wdata  (w64_wdata),
      .mem_gnt    (mem_gnt[1]),
      .mem_rvalid (mem_rvalid[1]),
      .mem_rdata  (mem_rdata[1])
   );

   assign mem_wdata[0] = {32'd0, w32_wdata};
   assign mem_wdata[1] = w64_wdata;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   //---------------------------------------------------------------------------
   // Reference model: what a store must do, from byte-level rules.
   // cls: 0 rejected, 1 single full-word write, 2 read-modify-write
   //---------------------------------------------------------------------------
   function automatic void model(input int u, input logic [31:0] addr,
                                 input logic [63:0] data, input logic [2:0] f3,
                                 input logic [63:0] rdata, output int cls,
                                 output logic [31:0] waddr, output logic [63:0] wdata);
      int          nb;
      int          sz;
      int          off;
      bit          misal;
      logic [63:0] dmask;
      nb    = (u == 0) ? 4 : 8;
      dmask = (u == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      sz    = 1 << f3[1:0];
      off   = int'(addr % 32'(nb));
      waddr = addr - 32'(off);
      wdata = '0;
      misal = 1'b0;
`ifdef STORE_MISALIGN_CHECK_EN
      misal = (addr % 32'(sz)) != 0;
`endif
      if (f3[2] || sz > nb) begin
         cls = 0;
      end else if (misal) begin
         cls = 0;
      end else if (sz == nb) begin
         cls   = 1;
         wdata = data & dmask;
      end else begin
         cls   = 2;
         off   = off - (off % sz);
         wdata = rdata & dmask;
         for (int i = 0; i < sz; i++) begin
            wdata[(off + i)*8 +: 8] = data[i*8 +: 8];
         end
      end
      if (cls == 0) waddr = '0;
   endfunction

   //---------------------------------------------------------------------------
   // Memory responder
   //---------------------------------------------------------------------------
   initial begin
      mem_gnt    = '0;
      mem_rvalid = '0;
      mem_rdata  = '0;
      for (int u = 0; u < 2; u++) begin
         pend[u] = 1'b0; gnt_cfg[u] = 0; gnt_cnt[u] = 0; rv_cfg[u] = 0; rv_cnt[u] = 0;
         rd_cfg[u] = '0;
      end
      forever begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            if (pend[u]) begin
               if (rv_cnt[u] == 0) begin
                  mem_rvalid[u] = 1'b1;
                  mem_rdata[u]  = rd_cfg[u];
                  pend[u]       = 1'b0;
               end else begin
                  mem_rvalid[u] = 1'b0;
                  rv_cnt[u]     = rv_cnt[u] - 1;
               end
            end else begin
               mem_rvalid[u] = ($urandom_range(0, 3) == 0);
               mem_rdata[u]  = {$urandom, $urandom};
            end
            if (mem_req[u] && !rst) begin
               if (gnt_cnt[u] == 0) begin
                  mem_gnt[u] = 1'b1;
                  gnt_cnt[u] = gnt_cfg[u];
                  if (!mem_we[u]) begin
                     pend[u]   = 1'b1;
                     rv_cnt[u] = rv_cfg[u];
                  end
               end else begin
                  mem_gnt[u] = 1'b0;
                  gnt_cnt[u] = gnt_cnt[u] - 1;
               end
            end else begin
               mem_gnt[u] = 1'b0;
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Monitor / scoreboard
   //---------------------------------------------------------------------------
   task automatic check_ev(input int u, input int k, input logic [31:0] a, input logic [63:0] wd);
      ev_t e;
      bit  ok;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event unit=%0d kind=%0d addr=%h wdata=%h cyc=%0d (nothing expected)",
                  u, k, a, wd, cyc);
         return;
      end
      e  = exp_q.pop_front();
      ok = (e.unit == u) && (e.kind == k) && (e.cyc == cyc);
      if (k == K_RD || k == K_WR) ok = ok && (e.addr == a);
      if (k == K_WR) ok = ok && (e.wdata == wd);
      if (!ok) begin
         errors++;
         $display("FAIL event got unit=%0d kind=%0d addr=%h wdata=%h cyc=%0d, required unit=%0d kind=%0d addr=%h wdata=%h cyc=%0d",
                  u, k, a, wd, cyc, e.unit, e.kind, e.addr, e.wdata, e.cyc);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            for (int u = 0; u < 2; u++) begin
               if (mem_req[u] && mem_gnt[u])
                  check_ev(u, mem_we[u] ? K_WR : K_RD, mem_addr[u], mem_wdata[u]);
               if (st_done[u]) check_ev(u, K_DONE, '0, '0);
               if (st_err[u])  check_ev(u, K_ERR, '0, '0);
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus helpers
   //---------------------------------------------------------------------------
   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic push_ev(input int u, input int k, input logic [31:0] a,
                          input logic [63:0] wd, input int c);
      ev_t e;
      e.unit = u; e.kind = k; e.addr = a; e.wdata = wd; e.cyc = c;
      exp_q.push_back(e);
   endtask

   // Present the request and return at the negedge where it is being accepted.
   task automatic hs_begin(input int u, input logic [31:0] addr, input logic [63:0] data,
                           input logic [2:0] f3, output int acc, output bit ok);
      int n;
      @(negedge clk);
      st_valid[u]  = 1'b1;
      st_addr[u]   = addr;
      st_data[u]   = data;
      st_funct3[u] = f3;
      n = 0;
      while (!st_ready[u] && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok  = st_ready[u];
      acc = cyc;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL handshake unit=%0d st_ready=0 required=1 after 50 cycles", u);
         st_valid[u] = 1'b0;
      end
   endtask

   // Drop valid and scramble the request inputs; the DUT must not notice.
   task automatic hs_end(input int u);
      @(negedge clk);
      st_valid[u]  = 1'b0;
      st_addr[u]   = $urandom;
      st_data[u]   = {$urandom, $urandom};
      st_funct3[u] = 3'($urandom);
   endtask

   task automatic wait_empty(input int limit);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout pending_events=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // One complete store. With use_exp set, the given expectation replaces the model.
   task automatic do_store(input int u, input logic [31:0] addr, input logic [63:0] data,
                           input logic [2:0] f3, input logic [63:0] rdata,
                           input int gw, input int rw, input bit use_exp,
                           input int x_cls, input logic [31:0] x_wa, input logic [63:0] x_wd);
      int          cls;
      logic [31:0] wa;
      logic [63:0] wd;
      int          acc;
      int          r;
      bit          ok;
      model(u, addr, data, f3, rdata, cls, wa, wd);
      if (use_exp) begin
         cls = x_cls; wa = x_wa; wd = x_wd;
      end
      gnt_cfg[u] = gw;
      gnt_cnt[u] = gw;
      rv_cfg[u]  = rw;
      rd_cfg[u]  = rdata;
      hs_begin(u, addr, data, f3, acc, ok);
      if (!ok) return;
      case (cls)
         0: push_ev(u, K_ERR, '0, '0, acc + 1);
         1: begin
            push_ev(u, K_WR,   wa, wd, acc + 1 + gw);
            push_ev(u, K_DONE, '0, '0, acc + 2 + gw);
         end
         default: begin
            r = acc + 1 + gw;
            push_ev(u, K_RD,   wa, '0, r);
            push_ev(u, K_WR,   wa, wd, r + 2 + rw + gw);
            push_ev(u, K_DONE, '0, '0, r + 3 + rw + gw);
         end
      endcase
      hs_end(u);
      wait_empty(200);
      $display("store unit=%0d f3=%0d addr=%h data=%h gnt_wait=%0d rv_wait=%0d class=%0d waddr=%h wdata=%h",
               u, f3, addr, data, gw, rw, cls, wa, wd);
   endtask

   //---------------------------------------------------------------------------
   // Main sequence
   //---------------------------------------------------------------------------
   initial begin
      int          cls_dummy;
      int          acc;
      bit          ok;
      bit          saw;
      int          u;
      logic [2:0]  f3;
      st_valid  = '0;
      st_addr   = '0;
      st_data   = '0;
      st_funct3 = '0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);

      // reset state of both instances
      for (int k = 0; k < 2; k++) begin
         check_val("rst_st_ready",  64'(st_ready[k]),  64'd1);
         check_val("rst_st_done",   64'(st_done[k]),   64'd0);
         check_val("rst_st_err",    64'(st_err[k]),    64'd0);
         check_val("rst_mem_req",   64'(mem_req[k]),   64'd0);
         check_val("rst_mem_we",    64'(mem_we[k]),    64'd0);
         check_val("rst_mem_addr",  64'(mem_addr[k]),  64'd0);
         check_val("rst_mem_wdata", mem_wdata[k],      64'd0);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // sb into lane 3 of a 32-bit word, best-case timing (done at N+4)
      do_store(0, 32'h1003, 64'hAB, 3'b000, 64'h1122_3344, 0, 0,
               1'b1, 2, 32'h1000, 64'hAB22_3344);
      repeat (2) @(negedge clk);

      // full-width sw, single write, done at N+2
      do_store(0, 32'h2000, 64'hDEAD_BEEF, 3'b010, 64'h0, 0, 0,
               1'b1, 1, 32'h2000, 64'hDEAD_BEEF);
      repeat (2) @(negedge clk);

      // sw into upper half of a 64-bit word
      do_store(1, 32'h14, 64'hCAFE_F00D, 3'b010, 64'h0123_4567_89AB_CDEF, 0, 0,
               1'b1, 2, 32'h10, 64'hCAFE_F00D_89AB_CDEF);
      repeat (2) @(negedge clk);

      // misaligned sh
`ifdef STORE_MISALIGN_CHECK_EN
      do_store(0, 32'h1001, 64'hBEEF, 3'b001, 64'h1122_3344, 0, 0,
               1'b1, 0, 32'h0, 64'h0);
`else
      do_store(0, 32'h1001, 64'hBEEF, 3'b001, 64'h1122_3344, 0, 0,
               1'b1, 2, 32'h1000, 64'h1122_BEEF);
`endif
      repeat (2) @(negedge clk);

      // sd on a 32-bit word: rejected, ready again the following cycle
      do_store(0, 32'h4000, 64'h1234_5678, 3'b011, 64'h0, 0, 0,
               1'b1, 0, 32'h0, 64'h0);
      check_val("err_ready_next", 64'(st_ready[0]), 64'd1);
      repeat (2) @(negedge clk);

      // full-width sd on the 64-bit word
      do_store(1, 32'h28, 64'h0BAD_F00D_1234_5678, 3'b011, 64'h0, 1, 0,
               1'b1, 1, 32'h28, 64'h0BAD_F00D_1234_5678);
      repeat (2) @(negedge clk);

      // grant held off 5 cycles, then reset while the read is outstanding
      gnt_cfg[0] = 5;
      gnt_cnt[0] = 5;
      rv_cfg[0]  = 4;
      rd_cfg[0]  = 64'h5555_5555;
      hs_begin(0, 32'h3002, 64'h5A, 3'b000, acc, ok);
      if (ok) begin
         push_ev(0, K_RD, 32'h3000, '0, acc + 6);
         hs_end(0);
         wait_empty(100);
         check_val("rd_wait_no_req",   64'(mem_req[0]),  64'd0);
         check_val("rd_wait_not_ready", 64'(st_ready[0]), 64'd0);
         rst = 1'b1;
         #1;
         check_val("midrst_ready",    64'(st_ready[0]), 64'd1);
         check_val("midrst_mem_req",  64'(mem_req[0]),  64'd0);
         check_val("midrst_mem_addr", 64'(mem_addr[0]), 64'd0);
         repeat (2) @(negedge clk);
         rst = 1'b0;
         saw = 1'b0;
         repeat (12) begin
            @(negedge clk);
            #1;
            if (mem_req[0] || st_done[0] || st_err[0] || !st_ready[0]) saw = 1'b1;
         end
         check_val("abandoned_store_quiet", 64'(saw), 64'd0);
         $display("store unit=0 f3=0 addr=00003002 abandoned by reset in RD_WAIT");
      end

      // randomized stores on both widths
      for (int i = 0; i < 60; i++) begin
         u  = $urandom_range(0, 1);
         f3 = 3'($urandom_range(0, 3));
         do_store(u, $urandom, {$urandom, $urandom}, f3, {$urandom, $urandom},
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 0, '0, '0);
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      cls_dummy = exp_q.size();
      check_val("scoreboard_drained", 64'(cls_dummy), 64'd0);
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
